// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with runtime-loadable pattern and optional overlap.
// Define SEQ_DETECT_COUNT_EN to build in the saturating match counter; otherwise match_count is tied to 0.
module seq_detect_param #(
   parameter int                 PAT_LEN   = 4,
   parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b1110,
   parameter int                 CNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               seq_in,
   input  logic               in_valid,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic               pat_load,
   input  logic               overlap_en,
   input  logic               count_clr,
   output logic               detected,
   output logic               detected_q,
   output logic [CNT_W-1:0]   match_count
);
   localparam int            FW   = $clog2(PAT_LEN);
   localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);
   logic [PAT_LEN-1:0] pat_q, pat_d, win;
   logic [PAT_LEN-2:0] hist_q, hist_d;
   logic [FW-1:0]      fill_q, fill_d;
   logic               det_q;
   assign win        = {hist_q, seq_in};
   assign detected   = in_valid && !pat_load && !reset && fill_q == FULL && win == pat_q;
   assign detected_q = det_q;
   // A non-overlapping match forgets the shifted history by restarting the fill count.
   always_comb begin
      pat_d  = pat_load ? pattern : pat_q;
      hist_d = pat_load ? '0 : in_valid ? win[PAT_LEN-2:0] : hist_q;
      fill_d = pat_load || (detected && !overlap_en) ? '0 :
               in_valid && fill_q != FULL ? fill_q + FW'(1) : fill_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q  <= RESET_PAT;
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= detected;
      end
   end
`ifdef SEQ_DETECT_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = count_clr ? '0 : detected && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   assign match_count = cnt_q;
`else
   logic unused_count_clr;
   assign unused_count_clr = count_clr;
   assign match_count      = '0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench for seq_detect_param; expected detections are queued as bits are driven.
module tb_seq_detect_param;
`ifdef SEQ_DETECT_COUNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif
   logic       clk = 1'b0, reset = 1'b1, seq_in = 1'b0, in_valid = 1'b0;
   logic [3:0] pattern = 4'b0000;
   logic       pat_load = 1'b0, overlap_en = 1'b0, count_clr = 1'b0;
   logic       detected, detected_q, sat_unused_det, sat_unused_dq;
   logic [7:0] match_count;
   logic [1:0] mc2;
   int         passed = 0, total = 0;
   bit         exp_q[$], det_obs[$], dq_obs[$];

   seq_detect_param dut (
      .clk(clk), .reset(reset), .seq_in(seq_in), .in_valid(in_valid), .pattern(pattern),
      .pat_load(pat_load), .overlap_en(overlap_en), .count_clr(count_clr),
      .detected(detected), .detected_q(detected_q), .match_count(match_count));

   seq_detect_param #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .seq_in(seq_in), .in_valid(in_valid), .pattern(pattern),
      .pat_load(pat_load), .overlap_en(overlap_en), .count_clr(count_clr),
      .detected(sat_unused_det), .detected_q(sat_unused_dq), .match_count(mc2));

   always #5 clk = ~clk;

   task automatic cyc(input bit v, input bit s, input bit ld, input bit clr, input bit e);
      @(negedge clk);
      in_valid = v; seq_in = s; pat_load = ld; count_clr = clr;
      exp_q.push_back(e);
      #1 det_obs.push_back(detected);
      @(posedge clk);
      #1 dq_obs.push_back(detected_q);
   endtask

   task automatic test_reset;
      in_valid = 1'b1; seq_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 total += 4;
      if (detected !== 1'b0) $display("FAIL reset detected: got %b want 0", detected); else passed++;
      if (detected_q !== 1'b0) $display("FAIL reset detected_q: got %b want 0", detected_q); else passed++;
      if (match_count !== 8'd0) $display("FAIL reset match_count: got %0d want 0", match_count); else passed++;
      if (mc2 !== 2'd0) $display("FAIL reset sat_count: got %0d want 0", mc2); else passed++;
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b0;
   endtask

   task automatic test_default_stream;
      bit [7:0] s = 8'b11101110, ex = 8'b00010001;
      bit e, d, q;
      overlap_en = 1'b0;
      cyc(0, 0, 0, 1, 0);
      for (int i = 7; i >= 0; i--) cyc(1, s[i], 0, 0, ex[i]);
      cyc(0, 0, 0, 0, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         e = exp_q.pop_front(); d = det_obs.pop_front(); q = dq_obs.pop_front(); total += 2;
         if (d !== e) $display("FAIL default detected[%0d]: got %b want %b", n, d, e); else passed++;
         if (q !== e) $display("FAIL default detected_q[%0d]: got %b want %b", n, q, e); else passed++;
      end
      total++;
      if (match_count !== 8'(2 * CNT_ON)) $display("FAIL default match_count: got %0d want %0d", match_count, 2 * CNT_ON); else passed++;
   endtask

   task automatic test_overlap;
      bit [5:0] s = 6'b101010, ex_on = 6'b000101, ex_off = 6'b000100;
      bit e, d, q;
      pattern = 4'b1010; overlap_en = 1'b1;
      cyc(1, 1, 1, 0, 0);
      for (int i = 5; i >= 0; i--) cyc(1, s[i], 0, 0, ex_on[i]);
      overlap_en = 1'b0;
      cyc(1, 1, 1, 0, 0);
      for (int i = 5; i >= 0; i--) cyc(1, s[i], 0, 0, ex_off[i]);
      for (int n = 0; exp_q.size() != 0; n++) begin
         e = exp_q.pop_front(); d = det_obs.pop_front(); q = dq_obs.pop_front(); total += 2;
         if (d !== e) $display("FAIL overlap detected[%0d]: got %b want %b", n, d, e); else passed++;
         if (q !== e) $display("FAIL overlap detected_q[%0d]: got %b want %b", n, q, e); else passed++;
      end
      total++;
      if (match_count !== 8'(5 * CNT_ON)) $display("FAIL overlap match_count: got %0d want %0d", match_count, 5 * CNT_ON); else passed++;
   endtask

   task automatic test_idle_gap;
      bit e, d, q;
      pattern = 4'b1110;
      cyc(0, 0, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         e = exp_q.pop_front(); d = det_obs.pop_front(); q = dq_obs.pop_front(); total += 2;
         if (d !== e) $display("FAIL idle detected[%0d]: got %b want %b", n, d, e); else passed++;
         if (q !== e) $display("FAIL idle detected_q[%0d]: got %b want %b", n, q, e); else passed++;
      end
   endtask

   task automatic test_restart;
      bit [7:0] s = 8'b11011110, ex = 8'b00000001;
      bit e, d, q;
      overlap_en = 1'b0;
      repeat (3) cyc(1, 1, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      #2 total++;
      if (match_count !== 8'd0) $display("FAIL restart reset match_count: got %0d want 0", match_count); else passed++;
      reset = 1'b0;
      cyc(1, 0, 0, 0, 0);
      repeat (3) cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      for (int i = 7; i >= 0; i--) cyc(1, s[i], 0, 0, ex[i]);
      cyc(0, 0, 0, 0, 0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         e = exp_q.pop_front(); d = det_obs.pop_front(); q = dq_obs.pop_front(); total += 2;
         if (d !== e) $display("FAIL restart detected[%0d]: got %b want %b", n, d, e); else passed++;
         if (q !== e) $display("FAIL restart detected_q[%0d]: got %b want %b", n, q, e); else passed++;
      end
      total++;
      if (match_count !== 8'(CNT_ON)) $display("FAIL restart match_count: got %0d want %0d", match_count, CNT_ON); else passed++;
   endtask

   task automatic test_count_sat;
      bit e, d, q;
      cyc(0, 0, 0, 1, 0);
      total += 2;
      if (match_count !== 8'd0) $display("FAIL clr match_count: got %0d want 0", match_count); else passed++;
      if (mc2 !== 2'd0) $display("FAIL clr sat_count: got %0d want 0", mc2); else passed++;
      pattern = 4'b1111; overlap_en = 1'b1;
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, i >= 3);
      total += 2;
      if (match_count !== 8'(5 * CNT_ON)) $display("FAIL sat match_count: got %0d want %0d", match_count, 5 * CNT_ON); else passed++;
      if (mc2 !== 2'(3 * CNT_ON)) $display("FAIL sat sat_count: got %0d want %0d", mc2, 3 * CNT_ON); else passed++;
      cyc(1, 1, 0, 1, 1);
      total += 2;
      if (match_count !== 8'd0) $display("FAIL clr_win match_count: got %0d want 0", match_count); else passed++;
      if (mc2 !== 2'd0) $display("FAIL clr_win sat_count: got %0d want 0", mc2); else passed++;
      cyc(1, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      total += 2;
      if (match_count !== 8'(CNT_ON)) $display("FAIL post_clr match_count: got %0d want %0d", match_count, CNT_ON); else passed++;
      if (mc2 !== 2'(CNT_ON)) $display("FAIL post_clr sat_count: got %0d want %0d", mc2, CNT_ON); else passed++;
      for (int n = 0; exp_q.size() != 0; n++) begin
         e = exp_q.pop_front(); d = det_obs.pop_front(); q = dq_obs.pop_front(); total += 2;
         if (d !== e) $display("FAIL count detected[%0d]: got %b want %b", n, d, e); else passed++;
         if (q !== e) $display("FAIL count detected_q[%0d]: got %b want %b", n, q, e); else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_default_stream;
      test_overlap;
      test_idle_gap;
      test_restart;
      test_count_sat;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter RESET_PAT, default 4'b1110 (PAT_LEN bits): pattern loaded at reset.
REQ-003 Parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 seq_in  input  1  serial data bit.
REQ-007 in_valid  input  1  seq_in is sampled this cycle.
REQ-008 pattern  input  PAT_LEN  new pattern; MSB is the earliest bit, bit 0 is the most recent bit.
REQ-009 pat_load  input  1  capture pattern and restart detection.
REQ-010 overlap_en  input  1  1 allows overlapping matches; 0 restarts after each match.
REQ-011 count_clr  input  1  synchronous clear of match_count.
REQ-012 detected  output  1  Mealy match flag, combinational in the same cycle as the final bit.
REQ-013 detected_q  output  1  detected registered by one clock.
REQ-014 match_count  output  CNT_W  number of matches.

Function
REQ-015 The block holds pat_reg (PAT_LEN bits), a history register hist (PAT_LEN-1 bits, newest bit at bit 0) and a fill counter fill (0..PAT_LEN-1, saturating).
REQ-016 detected SHALL be 1 only when all of these hold: in_valid=1, pat_load=0, fill=PAT_LEN-1, and {hist,seq_in}=pat_reg.
REQ-017 On each clock with in_valid=1 and pat_load=0:
- hist SHALL shift left with seq_in entering at bit 0.
- fill SHALL increment, saturating at PAT_LEN-1.
REQ-018 When in_valid=0, hist and fill SHALL hold and detected SHALL be 0; idle cycles do not break a partial match.
REQ-019 On a detection cycle with overlap_en=0, fill SHALL be set to 0; the shift still occurs but the shifted history is disregarded.
REQ-020 On a detection cycle with overlap_en=1, fill SHALL remain PAT_LEN-1, so for example pattern 1010 matches twice on the stream 101010.
REQ-021 overlap_en SHALL be sampled every cycle; changing it takes effect on the next detection.
REQ-022 On pat_load=1:
- pat_reg SHALL be set to pattern, hist to 0 and fill to 0 at the next edge.
- seq_in in that cycle SHALL be ignored.
- pat_load has priority over in_valid.
REQ-023 detected_q SHALL equal detected delayed by one clock.
REQ-024 The first detection is possible on the PAT_LEN-th valid bit after reset or pat_load.

Reset
REQ-025 When reset=1, the block SHALL asynchronously set pat_reg=RESET_PAT, hist=0, fill=0, detected_q=0 and match_count=0.
REQ-026 detected SHALL be 0 while reset is asserted.
REQ-027 Reset asserted in the middle of a partial match SHALL discard that match completely, with no detection on the following bits unless a full pattern is received again.

Configuration
REQ-028 Macro SEQ_DETECT_COUNT_EN compiles the match counter in or out.
REQ-029 With SEQ_DETECT_COUNT_EN defined:
- match_count SHALL increment by 1 on each edge where detected=1.
- match_count SHALL saturate at 2^CNT_W-1.
- count_clr SHALL set it to 0; if count_clr and detected occur in the same cycle, count_clr wins and the result is 0.
- pat_load SHALL NOT clear match_count.
REQ-030 Without SEQ_DETECT_COUNT_EN, the match_count port SHALL remain present and be driven constant 0, and count_clr SHALL be ignored.

Verification
REQ-031 Defaults, overlap_en=0, stream 1,1,1,0,1,1,1,0 → detected=1 on bits 4 and 8 only; match_count=2 (macro on).
REQ-032 Pattern 1010 loaded, overlap_en=1, stream 1,0,1,0,1,0 → detected on bits 4 and 6. With overlap_en=0 → detected on bit 4 only.
REQ-033 Default pattern, stream 1,1,in_valid=0 for 3 cycles,1,0 → detected=1 on the 0 bit; detected_q=1 one cycle later.
REQ-034 Default pattern, stream 1,1,1, reset pulse, then 0 → no detection. pat_load asserted mid-stream with seq_in=0 → no detection until PAT_LEN new valid bits have been received.
REQ-035 CNT_W=2, 5 matches → match_count=3 (saturated). count_clr asserted in the same cycle as a match → match_count=0.
REQ-036 Built without SEQ_DETECT_COUNT_EN, scenario REQ-031 → detected identical to REQ-031; match_count=0 throughout.
